imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface; the program counter is the initiator.
- Accepts a 32-bit instruction address (ia) with a request strobe and returns the addressed instruction word after a fixed, parameterised latency.
- Holds an internal word array of program storage, filled through a separate load port.
- Optional fault detection for misaligned and out-of-range fetches.

Parameters:
- BASE_ADDR, 32'h80000000, byte address mapped to word index 0; matches the PC reset vector.
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, >= 2.
- LATENCY, 2, cycles from request accept to valid; legal range 1..15.
- NOP_WORD, 32'h00000000, value driven on rd at reset and on faulted responses.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- req  input  1  fetch request; accepted on a rising edge when req=1 and ready=1.
- ia  input  32  byte address of the instruction; sampled on accept.
- ready  output  1  responder can accept a request this cycle.
- valid  output  1  rd/fault hold a response; one-cycle pulse.
- rd  output  32  instruction word; held until the next response.
- fault  output  1  response is faulted; meaningful only when valid=1.
- ld_en  input  1  load-port write enable.
- ld_addr  input  $clog2(DEPTH_WORDS)  word index to write.
- ld_data  input  32  word to write.

Behaviour:
- Reset (reset=0, async):
  - State -> IDLE, valid=0, fault=0, rd=NOP_WORD, latency counter=0.
  - Any pending request is dropped; no valid is ever produced for it.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- ready=1 in IDLE and RESP; ready=0 in WAIT. Exactly one request is outstanding at most.
- Accept (req=1 and ready=1, from IDLE or RESP):
  - Capture ia into addr_q.
  - LATENCY=1: next state RESP.
  - Otherwise: next state WAIT, counter = LATENCY-2.
- WAIT: counter decrements each cycle; when counter=0, next state RESP.
- Response latency: valid=1 exactly LATENCY cycles after the accepting edge.
- RESP: valid=1 for one cycle.
  - If req=1 in this cycle, a new request is accepted (back-to-back allowed).
  - Otherwise, next state IDLE.
- No backpressure: the initiator must consume a response in its valid cycle.
- rd and fault are registered on the edge entering RESP. rd holds its value until the next response.
- Index computation: offset = addr_q - BASE_ADDR (32-bit, modulo 2^32); index = offset[2+:$clog2(DEPTH_WORDS)].
- Load port:
  - On any rising edge with ld_en=1, mem[ld_addr] <= ld_data, in every state.
  - Same-edge collision: if a load hits the index being read on the edge entering RESP, rd returns the OLD contents. The new value is visible from the next edge on.
- req while in WAIT is ignored; the initiator must hold it until ready=1.

Optional Feature:
- Macro: IMEM_FAULT_EN.
- Defined:
  - fault=1 on a response if addr_q[1:0] != 0, or offset >= DEPTH_WORDS*4.
  - The offset test also catches addresses below BASE_ADDR through unsigned wrap.
  - A faulted response still arrives after LATENCY cycles with valid=1, rd=NOP_WORD, and no array read.
- Undefined:
  - fault is tied to 0.
  - addr_q[1:0] is ignored.
  - The index wraps modulo DEPTH_WORDS; every address returns an array word.

Test Plan:
- Reset: drive reset=0 mid-run -> immediately valid=0, fault=0, rd=0x00000000; ready=1 after reset=1.
- Basic fetch (LATENCY=2):
  - Stimulus: load mem[0]=0x20080005, then req with ia=0x80000000 at edge N.
  - Response: ready=0 during cycle N+1; valid=1 with rd=0x20080005 at cycle N+2 only.
- Back-to-back:
  - Stimulus: mem[1]=0x01095020; assert req with ia=0x80000004 during the RESP cycle of the previous fetch.
  - Response: accepted there; next valid with rd=0x01095020 arrives 2 cycles later; valid is never high two consecutive cycles.
- Reset mid-WAIT: accept ia=0x80000000, then assert reset=0 one cycle later -> no valid; state IDLE; ready=1 after release.
- Load collision: ld_en to index 3 with 0xDEADBEEF on the same edge a fetch of 0x8000000C enters RESP -> rd returns the old word; a refetch returns 0xDEADBEEF.
- Fault:
  - ia=0x80000002 -> with IMEM_FAULT_EN: valid=1, fault=1, rd=0. Without: rd=mem[0], fault=0.
  - ia=0x80000400 -> with IMEM_FAULT_EN: fault=1. Without: wraps to mem[0].

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch of words from a loadable array.
// Define IMEM_FAULT_EN to flag misaligned/out-of-range fetches as faulted responses.
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  input  logic [31:0]                    ia,
  output logic                           ready,
  output logic                           valid,
  output logic [31:0]                    rd,
  output logic                           fault,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_rd;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic [31:0]   w_rd_addr;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;

  assign ready    = (r_state != S_WAIT);
  assign valid    = (r_state == S_RESP);
  assign rd       = r_rd;
  assign w_accept = req & ready;

  // With LATENCY=1 the read happens on the accepting edge, so take ia directly.
  assign w_rd_addr = (r_state == S_WAIT) ? r_addr : ia;
  assign w_off     = w_rd_addr - BASE_ADDR;
  assign w_idx     = w_off[2 +: AW];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: begin
        if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= ia;
        r_cnt  <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Array has no reset; loads land in every state, including during reset.
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

`ifdef IMEM_FAULT_EN
  logic r_fault;
  logic w_flt;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  assign w_flt = (w_rd_addr[1:0] != 2'b00) || (w_off >= 32'(DEPTH_WORDS * 4));
  assign fault = r_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd    <= NOP_WORD;
      r_fault <= 1'b0;
    end else if (w_next == S_RESP) begin
      r_fault <= w_flt;
      r_rd    <= w_flt ? NOP_WORD : r_mem[w_idx];
    end
  end
`else
  logic [33-AW:0] w_unused;

  assign w_unused = {w_off[31:AW+2], w_off[1:0]};
  assign fault    = 1'b0;

  // Nonblocking read of r_mem gives the pre-load word on a same-edge collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_rd <= NOP_WORD;
    else if (w_next == S_RESP) r_rd <= r_mem[w_idx];
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed fetch/reset/collision/fault steps, then
// random traffic against a cycle-count reference model of the fetch protocol.
module tb_imem_responder;
  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;
  localparam logic [31:0] NOP   = 32'h00000000;
  localparam int          AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [31:0]   ia;
  logic          ready, valid, fault;
  logic [31:0]   rd;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  imem_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .ia(ia), .ready(ready), .valid(valid),
    .rd(rd), .fault(fault), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding fetch, counted down in whole cycles.
  logic [31:0] mem_m [DEPTH];
  bit          m_pend;
  int          m_remain;
  logic [31:0] m_addr;
  bit          m_valid;
  logic [31:0] m_rd;
  bit          m_fault;
  bit          prev_valid;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic respond(input logic [31:0] a);
    logic [31:0] off;
    off     = a - BASE;
    m_valid = 1'b1;
`ifdef IMEM_FAULT_EN
    if (a[1:0] != 2'b00 || off >= DEPTH * 4) begin
      m_fault = 1'b1;
      m_rd    = NOP;
    end else begin
      m_fault = 1'b0;
      m_rd    = mem_m[off / 4];
    end
`else
    m_fault = 1'b0;
    m_rd    = mem_m[(off / 4) % DEPTH];
`endif
  endtask

  // One clock: advance the model on the edge, then compare #1 later.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_rd    = NOP;
      m_fault = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_pend) begin
        m_remain--;
        if (m_remain == 0) begin
          m_pend = 1'b0;
          respond(m_addr);
        end
      end else if (req) begin
        m_addr   = ia;
        m_remain = LAT - 1;
        if (m_remain == 0) respond(m_addr);
        else               m_pend = 1'b1;
      end
    end
    if (ld_en) mem_m[ld_addr] = ld_data;
    #1;
    chk("ready", 32'(ready), 32'(!m_pend));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("rd", rd, m_rd);
    if (m_valid) begin
      chk("fault", 32'(fault), 32'(m_fault));
      chk("no_double_valid", 32'(prev_valid), 32'd0);
    end
    prev_valid = valid;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req = 1'b0; ia = 32'd0; ld_en = 1'b0; ld_addr = '0; ld_data = 32'd0;
    m_pend = 1'b0; m_remain = 0; m_addr = 32'd0; m_valid = 1'b0; m_rd = NOP; m_fault = 1'b0;
    prev_valid = 1'b0;
    repeat (2) tick();
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_rd", rd, NOP);
    chk("reset_fault", 32'(fault), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = $urandom;
      tick();
    end
    ld_addr = '0; ld_data = 32'h20080005;
    tick();
    ld_en = 1'b0;

    // Basic fetch, then back-to-back fetch issued in the RESP cycle.
    req = 1'b1; ia = 32'h80000000;
    tick();
    req = 1'b0;
    chk("basic_wait_ready", 32'(ready), 32'd0);
    ld_en = 1'b1; ld_addr = AW'(1); ld_data = 32'h01095020;
    tick();
    ld_en = 1'b0;
    chk("basic_valid", 32'(valid), 32'd1);
    chk("basic_rd", rd, 32'h20080005);
    req = 1'b1; ia = 32'h80000004;
    tick();
    req = 1'b0;
    chk("b2b_gap", 32'(valid), 32'd0);
    tick();
    chk("b2b_valid", 32'(valid), 32'd1);
    chk("b2b_rd", rd, 32'h01095020);
    tick();
    chk("b2b_after", 32'(valid), 32'd0);

    // Reset while a fetch is in WAIT: no response may ever appear.
    req = 1'b1; ia = 32'h80000000;
    tick();
    req = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("rst_wait_valid", 32'(valid), 32'd0);
    chk("rst_wait_fault", 32'(fault), 32'd0);
    chk("rst_wait_rd", rd, NOP);
    chk("rst_wait_ready", 32'(ready), 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_release_ready", 32'(ready), 32'd1);

    // Load collides with the read on the edge entering RESP.
    ld_en = 1'b1; ld_addr = AW'(3); ld_data = 32'h11111111;
    tick();
    ld_en = 1'b0;
    req = 1'b1; ia = 32'h8000000C;
    tick();
    req = 1'b0;
    ld_en = 1'b1; ld_addr = AW'(3); ld_data = 32'hDEADBEEF;
    tick();
    ld_en = 1'b0;
    chk("collide_valid", 32'(valid), 32'd1);
    chk("collide_old", rd, 32'h11111111);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("refetch_new", rd, 32'hDEADBEEF);

    // Misaligned and out-of-range fetches.
    req = 1'b1; ia = 32'h80000002;
    tick();
    req = 1'b0;
    tick();
    chk("misalign_valid", 32'(valid), 32'd1);
`ifdef IMEM_FAULT_EN
    chk("misalign_fault", 32'(fault), 32'd1);
    chk("misalign_rd", rd, NOP);
`else
    chk("misalign_fault", 32'(fault), 32'd0);
    chk("misalign_rd", rd, 32'h20080005);
`endif
    req = 1'b1; ia = 32'h80000400;
    tick();
    req = 1'b0;
    tick();
`ifdef IMEM_FAULT_EN
    chk("range_fault", 32'(fault), 32'd1);
`else
    chk("range_fault", 32'(fault), 32'd0);
    chk("range_wrap_rd", rd, 32'h20080005);
`endif
    tick();

    // Random traffic: requests every state, loads anywhere, mostly in-range addresses.
    for (int n = 0; n < 600; n++) begin
      req = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) ia = $urandom;
      else ia = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = AW'($urandom_range(0, DEPTH - 1));
      ld_data = $urandom;
      tick();
    end
    req = 1'b0; ld_en = 1'b0;
    repeat (LAT + 1) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
